// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream input and imem write port of the instruction-memory loader.
// Revision: 1.0
`default_nettype none

interface imem_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  // master = loader (drives the write port), slave = stream source / memory side
  modport master (
    input  in_valid, in_data,
    output in_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, wr_en, wr_addr, wr_data
  );
endinterface

`default_nettype wire

// File: rtl/imem_loader.sv
// imem_loader: loads a length-prefixed little-endian byte stream into instruction memory.
// Optional trailing XOR checksum byte enabled by macro IMEM_LOADER_CHECKSUM_EN. Revision: 1.0
`default_nettype none

module imem_loader #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  imem_loader_if.master bus,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          cpu_hold
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN   = 3'd1,
    DATA  = 3'd2,
    CSUM  = 3'd3,
    DONE  = 3'd4,
    ERROR = 3'd5
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        ready;
  logic        accept;
  logic        restart;
  logic        len_phase;
  logic [7:0]  len_lo;
  logic [15:0] len_word;
  logic [1:0]  byte_idx;
  logic [15:0] word_cnt;
  logic [15:0] word_total;
  logic [23:0] partial;
  logic [31:0] next_addr;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

`ifdef IMEM_LOADER_CHECKSUM_EN
  assign ready = (state == LEN) || (state == DATA) || (state == CSUM);
`else
  assign ready = (state == LEN) || (state == DATA);
`endif

  assign accept       = bus.in_valid && ready;
  assign restart      = start && ((state == IDLE) || (state == DONE) || (state == ERROR));
  assign len_word     = {bus.in_data, len_lo};
  assign bus.in_ready = ready;
  assign bus.wr_en    = wr_en;
  assign bus.wr_addr  = wr_addr;
  assign bus.wr_data  = wr_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    cpu_hold  = 1'b1;
    case (state)
      IDLE: begin
        if (start) state_nxt = LEN;
      end
      LEN: begin
        busy = 1'b1;
        if (accept && len_phase) begin
          if (len_word == 16'd0)
            state_nxt = CSUM;
          else if ({16'd0, len_word} > DEPTH_WORDS)
            state_nxt = ERROR;
          else
            state_nxt = DATA;
        end
      end
      DATA: begin
        busy = 1'b1;
        if (accept && (byte_idx == 2'd3) && (word_cnt + 16'd1 == word_total))
          state_nxt = CSUM;
      end
      CSUM: begin
        busy = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (accept) state_nxt = (bus.in_data == csum) ? DONE : ERROR;
`else
        state_nxt = DONE;
`endif
      end
      DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
        if (start) state_nxt = LEN;
      end
      ERROR: begin
        err = 1'b1;
        if (start) state_nxt = LEN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_phase  <= 1'b0;
      len_lo     <= 8'd0;
      byte_idx   <= 2'd0;
      word_cnt   <= 16'd0;
      word_total <= 16'd0;
      partial    <= 24'd0;
      next_addr  <= BASE_ADDR;
      wr_en      <= 1'b0;
      wr_addr    <= BASE_ADDR;
      wr_data    <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum       <= 8'd0;
`endif
    end else begin
      wr_en <= 1'b0;
      if (restart) begin
        len_phase  <= 1'b0;
        byte_idx   <= 2'd0;
        word_cnt   <= 16'd0;
        word_total <= 16'd0;
        next_addr  <= BASE_ADDR;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum       <= 8'd0;
`endif
      end
      if (accept) begin
        case (state)
          LEN: begin
            if (!len_phase) begin
              len_lo    <= bus.in_data;
              len_phase <= 1'b1;
            end else begin
              word_total <= len_word;
            end
          end
          DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum <= csum ^ bus.in_data;
`endif
            byte_idx <= byte_idx + 2'd1;
            // The write is registered here so it lands the cycle after the 4th byte.
            if (byte_idx == 2'd3) begin
              wr_en     <= 1'b1;
              wr_addr   <= next_addr;
              wr_data   <= {bus.in_data, partial};
              next_addr <= next_addr + 32'd4;
              word_cnt  <= word_cnt + 16'd1;
            end else begin
              case (byte_idx)
                2'd0:    partial[7:0]   <= bus.in_data;
                2'd1:    partial[15:8]  <= bus.in_data;
                default: partial[23:16] <= bus.in_data;
              endcase
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader (default parameters).
// Revision: 1.0
`default_nettype none

module tb_imem_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic busy, done, err, cpu_hold;

  imem_loader_if ifc ();

  imem_loader dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bus      (ifc),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .cpu_hold (cpu_hold)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int stalls = 0;
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  int          wc_q[$];

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (ifc.wr_en === 1'b1) begin
      wa_q.push_back(ifc.wr_addr);
      wd_q.push_back(ifc.wr_data);
      wc_q.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_q();
    wa_q.delete();
    wd_q.delete();
    wc_q.delete();
    stalls = 0;
  endtask

  task automatic send(input logic [7:0] b, input logic with_start = 1'b0);
    int t;
    @(negedge clk);
    ifc.in_valid = 1'b1;
    ifc.in_data  = b;
    start        = with_start;
    t = 0;
    while (!ifc.in_ready && t < 20) begin
      stalls++;
      t++;
      @(negedge clk);
      start = 1'b0;
    end
    if (t >= 20) check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle();
    @(negedge clk);
    ifc.in_valid = 1'b0;
    start        = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    ifc.in_valid = 1'b0;
    start        = 1'b1;
    @(negedge clk);
    start        = 1'b0;
  endtask

  task automatic send_len(input logic [15:0] n);
    send(n[7:0]);
    send(n[15:8]);
  endtask

  task automatic send_csum(input logic [7:0] c);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(c);
`else
    if (c === 8'hxx) $display("unused checksum");
`endif
  endtask

  task automatic wait_end();
    int t;
    t = 0;
    while (!(done || err) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) check("end_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_write(input string tag, input int k, input logic [31:0] a, input logic [31:0] d);
    if (k < wa_q.size()) begin
      check({tag, "_addr"}, wa_q[k], a);
      check({tag, "_data"}, wd_q[k], d);
    end else begin
      check({tag, "_missing"}, 32'd0, 32'd1);
    end
  endtask

  task automatic check_outputs(input string tag, input logic b, input logic d, input logic e, input logic h);
    check({tag, "_busy"}, {31'd0, busy}, {31'd0, b});
    check({tag, "_done"}, {31'd0, done}, {31'd0, d});
    check({tag, "_err"},  {31'd0, err},  {31'd0, e});
    check({tag, "_hold"}, {31'd0, cpu_hold}, {31'd0, h});
  endtask

  initial begin
    ifc.in_valid = 1'b0;
    ifc.in_data  = 8'd0;

    // Reset values
    #1;
    check_outputs("rst", 1'b0, 1'b0, 1'b0, 1'b1);
    check("rst_ready", {31'd0, ifc.in_ready}, 32'd0);
    check("rst_wr_en", {31'd0, ifc.wr_en}, 32'd0);
    check("rst_addr", ifc.wr_addr, 32'h0);
    check("rst_data", ifc.wr_data, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs("post_rst", 1'b0, 1'b0, 1'b0, 1'b1);

    // Single-word load
    clear_q();
    pulse_start();
    check("s1_ready", {31'd0, ifc.in_ready}, 32'd1);
    send_len(16'd1);
    send(8'h13); send(8'h05); send(8'hA0); send(8'h00);
    send_csum(8'hB6);
    idle();
    wait_end();
    check("s1_count", wa_q.size(), 32'd1);
    check_write("s1_w0", 0, 32'h0, 32'h00A00513);
    check_outputs("s1_end", 1'b0, 1'b1, 1'b0, 1'b0);

    // Three words, continuous stream
    clear_q();
    pulse_start();
    check_outputs("s2_start", 1'b1, 1'b0, 1'b0, 1'b1);
    send_len(16'd3);
    for (int i = 0; i < 12; i++) send(8'h10 + 8'(i));
    send_csum(8'h00);
    idle();
    wait_end();
    check("s2_count", wa_q.size(), 32'd3);
    check_write("s2_w0", 0, 32'h0, 32'h13121110);
    check_write("s2_w1", 1, 32'h4, 32'h17161514);
    check_write("s2_w2", 2, 32'h8, 32'h1B1A1918);
    if (wc_q.size() == 3) begin
      check("s2_gap01", wc_q[1] - wc_q[0], 32'd4);
      check("s2_gap12", wc_q[2] - wc_q[1], 32'd4);
    end
    check("s2_stalls", stalls, 32'd0);
    check_outputs("s2_end", 1'b0, 1'b1, 1'b0, 1'b0);

    // start during DATA is ignored
    clear_q();
    pulse_start();
    send_len(16'd2);
    send(8'hA0);
    send(8'hA1, 1'b1);
    for (int i = 2; i < 8; i++) send(8'hA0 + 8'(i));
    send_csum(8'h00);
    idle();
    wait_end();
    check("s3_count", wa_q.size(), 32'd2);
    check_write("s3_w0", 0, 32'h0, 32'hA3A2A1A0);
    check_write("s3_w1", 1, 32'h4, 32'hA7A6A5A4);
    check_outputs("s3_end", 1'b0, 1'b1, 1'b0, 1'b0);

    // Exactly DEPTH_WORDS words
    clear_q();
    pulse_start();
    send_len(16'h0100);
    for (int i = 0; i < 1024; i++) send(8'(i));
    send_csum(8'h00);
    idle();
    wait_end();
    check("s4_count", wa_q.size(), 32'd256);
    check_write("s4_last", 255, 32'h3FC, 32'hFFFEFDFC);
    check_outputs("s4_end", 1'b0, 1'b1, 1'b0, 1'b0);

    // Length above DEPTH_WORDS
    clear_q();
    pulse_start();
    send_len(16'h0101);
    idle();
    wait_end();
    check("s5_count", wa_q.size(), 32'd0);
    check_outputs("s5_end", 1'b0, 1'b0, 1'b1, 1'b1);
    check("s5_ready", {31'd0, ifc.in_ready}, 32'd0);

    // Reset mid-word, then reload
    clear_q();
    pulse_start();
    check("s6_err_clr", {31'd0, err}, 32'd0);
    send_len(16'd1);
    send(8'h11); send(8'h22);
    idle();
    rst = 1'b1;
    #1;
    check_outputs("s6_rst", 1'b0, 1'b0, 1'b0, 1'b1);
    check("s6_addr", ifc.wr_addr, 32'h0);
    check("s6_data", ifc.wr_data, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("s6_ready", {31'd0, ifc.in_ready}, 32'd0);
    check("s6_idle_busy", {31'd0, busy}, 32'd0);
    check("s6_nowrite", wa_q.size(), 32'd0);
    pulse_start();
    send_len(16'd1);
    send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
    send_csum(8'h22);
    idle();
    wait_end();
    check("s6_count", wa_q.size(), 32'd1);
    check_write("s6_w0", 0, 32'h0, 32'hEFBEADDE);

    // Zero-length load
    clear_q();
    pulse_start();
    send_len(16'd0);
    send_csum(8'h00);
    idle();
    wait_end();
    check("s7_count", wa_q.size(), 32'd0);
    check_outputs("s7_end", 1'b0, 1'b1, 1'b0, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Bad checksum
    clear_q();
    pulse_start();
    send_len(16'd1);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    send(8'h05);
    idle();
    wait_end();
    check("s8_count", wa_q.size(), 32'd1);
    check_write("s8_w0", 0, 32'h0, 32'h04030201);
    check_outputs("s8_end", 1'b0, 1'b0, 1'b1, 1'b1);
    pulse_start();
    check("s8_err_clr", {31'd0, err}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
